// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch/data requests onto one combinational memory port, checks the memory map
// and registers responses; define MAC_STATS_EN to add saturating fetch/load/store/fault ack counters.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int INST_BASE   = 1024,
  parameter int DATA_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_R,
  output logic        mem_W,
  input  logic [31:0] mem_out,
  output logic        busy
`ifdef MAC_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt,
  output logic [15:0] fault_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic last_f, cur_f, gnt_f, f_bad, d_bad;
  logic [3:0] cnt;
  always_comb begin
    gnt_f = if_req && (!d_req || !last_f);
    f_bad = if_addr < 32'(INST_BASE) || if_addr[1:0] != 2'b00;
    d_bad = d_addr >= 32'(DATA_WORDS);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_f    <= 1'b1;
      cur_f     <= 1'b0;
      cnt       <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_R     <= 1'b0;
      mem_W     <= 1'b0;
      if_ack    <= 1'b0;
      if_data   <= 32'd0;
      if_fault  <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= 32'd0;
      d_fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (if_req || d_req) begin
          cur_f  <= gnt_f;
          last_f <= gnt_f;
          cnt    <= 4'd0;
          if (gnt_f ? f_bad : d_bad) begin
            state    <= RESP;
            if_ack   <= gnt_f;
            d_ack    <= !gnt_f;
            if_fault <= gnt_f;
            d_fault  <= !gnt_f;
          end else begin
            state     <= ACCESS;
            mem_addr  <= gnt_f ? if_addr : d_addr;
            mem_wdata <= (!gnt_f && d_we) ? d_wdata : 32'd0;
            mem_R     <= gnt_f || !d_we;
            mem_W     <= !gnt_f && d_we;
          end
        end
        ACCESS: if (cnt == 4'(WAIT_CYCLES)) begin
          state     <= RESP;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          mem_R     <= 1'b0;
          mem_W     <= 1'b0;
          if_ack    <= cur_f;
          d_ack     <= !cur_f;
          if_data   <= cur_f ? mem_out : 32'd0;
          d_rdata   <= (!cur_f && mem_R) ? mem_out : 32'd0;
        end else cnt <= cnt + 4'd1;
        default: begin
          state    <= IDLE;
          if_ack   <= 1'b0;
          if_data  <= 32'd0;
          if_fault <= 1'b0;
          d_ack    <= 1'b0;
          d_rdata  <= 32'd0;
          d_fault  <= 1'b0;
        end
      endcase
    end
  end
`ifdef MAC_STATS_EN
  logic st_we;
  function automatic logic [15:0] sat(input logic [15:0] c, input logic e);
    return c + 16'(e && c != 16'hFFFF);
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_we     <= 1'b0;
      fetch_cnt <= 16'd0;
      load_cnt  <= 16'd0;
      store_cnt <= 16'd0;
      fault_cnt <= 16'd0;
    end else begin
      if (state == IDLE && d_req && !gnt_f) st_we <= d_we;
      fetch_cnt <= sat(fetch_cnt, if_ack && !if_fault);
      load_cnt  <= sat(load_cnt, d_ack && !d_fault && !st_we);
      store_cnt <= sat(store_cnt, d_ack && !d_fault && st_we);
      fault_cnt <= sat(fault_cnt, (if_ack && if_fault) || (d_ack && d_fault));
    end
  end
`endif
endmodule
